// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// The entry record is sized by XLEN, so fetch_unit is meant to run with ADDR_W == XLEN.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [XLEN-1:0] PC_LO_DEF      = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_HI_DEF      = 32'h0000_6FFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      exc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_iq.sv
// Synchronous FIFO holding fetched entries; supports flush and same-cycle push/pop.
// The caller must only push while full if it also pops in that cycle.
module fetch_iq
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register with redirect handling, feeding a small instruction queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [ADDR_W-1:0] PC_LO      = PC_LO_DEF,
    parameter logic [ADDR_W-1:0] PC_HI      = PC_HI_DEF,
    parameter int              IQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [ADDR_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        exc_req,
    output logic                        deq_valid,
    input  logic                        deq_ready,
    output logic [ADDR_W-1:0]           deq_pc,
    output logic [ADDR_W-1:0]           deq_instr,
    output logic [4:0]                  deq_exc,
    output logic [$clog2(IQ_DEPTH):0]   iq_count
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              pop;
    logic              enq;
    logic              bad_addr;
    fetch_entry_t      new_entry;
    fetch_entry_t      head;

    assign redirect  = exc_req || redirect_valid;
    assign deq_valid = (iq_count != '0);
    assign pop       = deq_valid && deq_ready;
    assign enq       = !redirect && ((iq_count < CW'(IQ_DEPTH)) || pop);
    assign imem_addr = pc;

    // Misaligned or out-of-range PCs still enqueue, but as an AdEL entry with no instruction.
    assign bad_addr = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);

    always_comb begin
        new_entry.pc    = pc;
        new_entry.instr = bad_addr ? '0 : imem_rdata;
        new_entry.exc   = bad_addr ? EXC_ADEL : EXC_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (exc_req)
            pc <= EXC_VECTOR;
        else if (redirect_valid)
            pc <= redirect_pc;
        else if (enq)
            pc <= pc + ADDR_W'(4);
    end

    fetch_iq #(
        .DEPTH   (IQ_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_iq (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (enq),
        .push_data (new_entry),
        .pop       (pop && !redirect),
        .head      (head),
        .count     (iq_count)
    );

    assign deq_pc    = head.pc;
    assign deq_instr = head.instr;
    assign deq_exc   = head.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an asynchronous-read memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [4:0]  deq_exc;
    logic [2:0]  iq_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns a recognisable pattern derived from the address.
    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = instrFor(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .deq_exc        (deq_exc),
        .iq_count       (iq_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive inputs at the falling edge, then step through one rising edge back to the next falling edge.
    task automatic applyStimulus(input logic rst, input logic exc, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        reset          = rst;
        exc_req        = exc;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq_ready      = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkHead(input string tag, input logic [31:0] pc, input logic [4:0] exc);
        checkOutput({tag, "_valid"}, 32'(deq_valid), 32'd1);
        checkOutput({tag, "_pc"}, deq_pc, pc);
        checkOutput({tag, "_exc"}, 32'(deq_exc), 32'(exc));
        checkOutput({tag, "_instr"}, deq_instr, (exc == 5'd0) ? instrFor(pc) : 32'd0);
    endtask

    initial begin
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_count", 32'(iq_count), 32'd0);
        checkOutput("rst_valid", 32'(deq_valid), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h3000);

        // Fill with decode stalled: four pushes, then PC parks at 0x3010.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("fill", 32'h3000, 5'd0);
        checkOutput("fill_count", 32'(iq_count), 32'd4);
        checkOutput("fill_addr", imem_addr, 32'h3010);

        // Full queue streaming: one pop and one push per cycle.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkHead($sformatf("stream%0d", k), 32'h3000 + 32'(4 * k), 5'd0);
            checkOutput($sformatf("stream%0d_count", k), 32'(iq_count), 32'd4);
        end

        // Branch redirect while full and popping.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h3100, 1'b1);
        checkOutput("redir_count", 32'(iq_count), 32'd0);
        checkOutput("redir_valid", 32'(deq_valid), 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h3100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("redir_tgt", 32'h3100, 5'd0);
        checkOutput("redir_tgt_count", 32'(iq_count), 32'd1);

        // Exception wins over a simultaneous branch redirect.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3200, 1'b0);
        checkOutput("exc_addr", imem_addr, 32'h4180);
        checkOutput("exc_count", 32'(iq_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("exc_tgt", 32'h4180, 5'd0);

        // Misaligned target is fetched as-is and flagged.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h3002, 1'b0);
        checkOutput("misal_addr", imem_addr, 32'h3002);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("misal", 32'h3002, 5'd4);

        // Above the legal window.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h7000, 1'b0);
        checkOutput("high_addr", imem_addr, 32'h7000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("high", 32'h7000, 5'd4);

        // Upper boundary: last legal word then first illegal one.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h6FFC, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("top_ok", 32'h6FFC, 5'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("top_bad", 32'h7000, 5'd4);
        checkOutput("top_count", 32'(iq_count), 32'd1);

        // Lower boundary.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h2FFC, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("low_bad", 32'h2FFC, 5'd4);

        // Mid-operation reset with three entries queued, exception also asserted.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h3040, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_count", 32'(iq_count), 32'd3);
        checkOutput("pre_rst_addr", imem_addr, 32'h304C);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("mid_rst_count", 32'(iq_count), 32'd0);
        checkOutput("mid_rst_valid", 32'(deq_valid), 32'd0);
        checkOutput("mid_rst_addr", imem_addr, 32'h3000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("post_rst", 32'h3000, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 32, address/instruction width in bits.
REQ-002 Parameter RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, 32'h0000_4180, PC value loaded on exception redirect.
REQ-004 Parameter PC_LO / PC_HI, 32'h0000_3000 / 32'h0000_6FFC, inclusive legal fetch range.
REQ-005 Parameter IQ_DEPTH, 4, instruction-queue entries; power of two, >=2.
REQ-006 The clock and reset SHALL be one clock and a synchronous, active-high reset, as listed below.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 imem_addr  out  ADDR_W  current PC; instruction memory is asynchronous read.
REQ-010 imem_rdata  in  ADDR_W  instruction at imem_addr, same cycle.
REQ-011 redirect_valid  in  1  branch/jump redirect from a later stage.
REQ-012 redirect_pc  in  ADDR_W  redirect target.
REQ-013 exc_req  in  1  exception/interrupt redirect to EXC_VECTOR.
REQ-014 deq_valid  out  1  queue head valid.
REQ-015 deq_ready  in  1  decode accepts head this cycle.
REQ-016 deq_pc / deq_instr  out  ADDR_W each  head PC and instruction.
REQ-017 deq_exc  out  5  head exception code; 0 = none, 4 = AdEL.
REQ-018 iq_count  out  $clog2(IQ_DEPTH)+1  occupied entries.

Function
REQ-019 imem_addr SHALL equal the PC register combinationally.
REQ-020 Push ("enq") SHALL occur when no redirect and (iq_count<IQ_DEPTH or pop fires this cycle); entry = {PC, instr, exc}.
REQ-021 On enq, PC SHALL advance to PC+4, modulo 2^ADDR_W; otherwise PC holds.
REQ-022 An entry SHALL get exc=4 and instr=0 when PC[1:0]!=0 or PC<PC_LO or PC>PC_HI; otherwise exc=0, instr=imem_rdata.
REQ-023 Pop SHALL fire when deq_valid and deq_ready; head advances next cycle.
REQ-024 deq_valid SHALL be 1 exactly when iq_count!=0; deq_* SHALL be driven from the head entry with no extra latency.
REQ-025 Push and pop in the same cycle SHALL leave iq_count unchanged, including when full.
REQ-026 Redirect priority SHALL be exc_req > redirect_valid > sequential.
REQ-027 On exc_req, PC SHALL become EXC_VECTOR and the queue SHALL empty next cycle; a same-cycle pop and push are discarded.
REQ-028 On redirect_valid without exc_req, PC SHALL become redirect_pc and the queue SHALL empty next cycle.
REQ-029 An instruction at a redirect target SHALL appear on deq_* no earlier than one cycle after the redirect cycle.
REQ-030 Read/write pointers SHALL wrap modulo IQ_DEPTH; iq_count SHALL never exceed IQ_DEPTH or underflow.
REQ-031 A misaligned redirect_pc SHALL be accepted and SHALL produce an exc=4 entry, not be corrected.

Reset
REQ-032 While reset: PC=RESET_PC, pointers=0, iq_count=0, deq_valid=0; reset overrides exc_req and redirect.
REQ-033 Reset asserted mid-operation SHALL discard all queue contents at the next edge.
REQ-034 Queue entry storage SHALL need no reset; deq_pc/deq_instr/deq_exc are don't-care while deq_valid=0.

Structure
REQ-035 Package fetch_pkg SHALL hold EXC_NONE=0, EXC_ADEL=4, the entry record type, and the default vectors.
REQ-036 Sub-module fetch_iq (parametrised synchronous FIFO with flush, same-cycle push/pop) SHALL hold the queue; PC logic stays in fetch_unit.

Verification
REQ-037 Reset, then deq_ready=0 for 6 cycles -> deq_pc=0x3000, iq_count=4, imem_addr holds 0x3010.
REQ-038 deq_ready=1 continuously -> one pop per cycle, deq_pc 0x3000, 0x3004, 0x3008…, iq_count steady.
REQ-039 Queue full, redirect_valid=1 with redirect_pc=0x3100 and deq_ready=1 -> next cycle iq_count=0, imem_addr=0x3100; the following cycle deq_pc=0x3100.
REQ-040 exc_req and redirect_valid (0x3200) in the same cycle -> imem_addr=0x4180 next cycle.
REQ-041 redirect_pc=0x3002, then redirect_pc=0x7000 -> each entry has deq_exc=4 and deq_instr=0; in-range aligned PCs give deq_exc=0.
REQ-042 reset asserted for one cycle with queue at 3 entries -> next cycle iq_count=0, deq_valid=0, imem_addr=0x3000.
